// File: rtl/bus_port_pkg.sv
// Shared types and helpers for the bus device port: ID width, ID position and destination decode.
package bus_port_pkg;

    localparam int ID_W          = 8;
    localparam int ID_MSB_OFFSET = 0;
    localparam int PKT_W_MAX     = 256;

    typedef logic [ID_W-1:0] port_id_t;

    // Callers zero-extend their packet to PKT_W_MAX and pass their real packet width.
    function automatic port_id_t get_dest_id(input logic [PKT_W_MAX-1:0] pkt, input int pkt_w);
        return pkt[pkt_w-1-ID_MSB_OFFSET -: ID_W];
    endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// First-word-fall-through circular buffer with registered count; writes when full and
// reads when empty are ignored, and rdata is forced to zero while empty.
module bus_sync_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrEn, rdEn;

    assign full  = (cnt_q == CNT_W'(depth));
    assign empty = (cnt_q == '0);
    assign wrEn  = wr & ~full;
    assign rdEn  = rd & ~empty;
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // Pointers wrap naturally because depth is a power of two.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (wrEn) wptr_d = wptr_q + PTR_W'(1);
        if (rdEn) rptr_d = rptr_q + PTR_W'(1);
        case ({wrEn, rdEn})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: TX queue drained by the bus, RX queue filled by the bus.
// Optional destination filtering on incoming packets is enabled by BUS_PORT_RX_FILTER_EN.
module bus_dev_port
    import bus_port_pkg::*;
#(
    parameter int       pckg_sz   = 32,
    parameter int       depth     = 8,
    parameter port_id_t drvr_id   = 8'd0,
    parameter port_id_t broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_valid,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_ready,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_ready,
    output logic [7:0]         rx_drop_cnt,
    output logic               pop_err
);

    logic       txFull, txEmpty, rxFull, rxEmpty;
    logic       pushAccept;
    logic [7:0] dropCnt_q, dropCnt_d;
    logic       popErr_q, popErr_d;

`ifdef BUS_PORT_RX_FILTER_EN
    port_id_t destId;
    assign destId     = get_dest_id(PKT_W_MAX'(D_push), pckg_sz);
    assign pushAccept = (destId == drvr_id) || (destId == broadcast);
`else
    logic unusedIds;
    assign unusedIds  = ^{drvr_id, broadcast};
    assign pushAccept = 1'b1;
`endif

    assign tx_ready    = ~txFull;
    assign pndng       = ~txEmpty;
    assign rx_valid    = ~rxEmpty;
    assign rx_drop_cnt = dropCnt_q;
    assign pop_err     = popErr_q;

    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_txFifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_valid & tx_ready),
        .wdata (tx_data),
        .rd    (pop & pndng),
        .rdata (D_pop),
        .full  (txFull),
        .empty (txEmpty)
    );

    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rxFifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push & pushAccept & ~rxFull),
        .wdata (D_push),
        .rd    (rx_valid & rx_ready),
        .rdata (rx_data),
        .full  (rxFull),
        .empty (rxEmpty)
    );

    // Fullness is judged on the registered count, so a same-cycle RX read never rescues a push.
    always_comb begin
        dropCnt_d = dropCnt_q;
        popErr_d  = popErr_q;
        if (push && pushAccept && rxFull && (dropCnt_q != 8'hFF))
            dropCnt_d = dropCnt_q + 8'd1;
        if (pop && !pndng)
            popErr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropCnt_q <= '0;
            popErr_q  <= 1'b0;
        end else begin
            dropCnt_q <= dropCnt_d;
            popErr_q  <= popErr_d;
        end
    end

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed and randomized checks of bus_dev_port against a queue-based reference model.
module tb_bus_dev_port;

    localparam int         PW    = 32;
    localparam int         DEPTH = 8;
    localparam logic [7:0] MY_ID = 8'h03;
    localparam logic [7:0] BCAST = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          pndng, pop, push, tx_valid, tx_ready, rx_valid, rx_ready, pop_err;
    logic [PW-1:0] D_pop, D_push, tx_data, rx_data;
    logic [7:0]    rx_drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] txQ[$];
    logic [PW-1:0] rxQ[$];
    int            dropM;
    bit            popErrM;

    always #5 clk = ~clk;

    bus_dev_port #(.pckg_sz(PW), .depth(DEPTH), .drvr_id(MY_ID), .broadcast(BCAST)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
    );

    function automatic bit accepts(input logic [PW-1:0] p);
`ifdef BUS_PORT_RX_FILTER_EN
        return (p[PW-1 -: 8] == MY_ID) || (p[PW-1 -: 8] == BCAST);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [PW-1:0] mkPkt(input logic [7:0] id);
        return {id, 24'($urandom)};
    endfunction

    task automatic check1(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        txQ.delete();
        rxQ.delete();
        dropM   = 0;
        popErrM = 1'b0;
    endtask

    task automatic checkOutput();
        check1("pndng",    PW'(pndng),    PW'(txQ.size() > 0));
        check1("D_pop",    D_pop,         (txQ.size() > 0) ? txQ[0] : '0);
        check1("tx_ready", PW'(tx_ready), PW'(txQ.size() < DEPTH));
        check1("rx_valid", PW'(rx_valid), PW'(rxQ.size() > 0));
        check1("rx_data",  rx_data,       (rxQ.size() > 0) ? rxQ[0] : '0);
        check1("drop_cnt", PW'(rx_drop_cnt), PW'(dropM));
        check1("pop_err",  PW'(pop_err),  PW'(popErrM));
    endtask

    // One clock cycle: drive inputs, let the edge pass, advance the model, compare.
    task automatic applyStimulus(input bit txV, input logic [PW-1:0] txD, input bit p,
                                 input bit pu, input logic [PW-1:0] puD, input bit rxR);
        bit txRoom, txAny, rxAny, rxRoom;
        tx_valid = txV; tx_data = txD; pop = p; push = pu; D_push = puD; rx_ready = rxR;
        txRoom = txQ.size() < DEPTH;
        txAny  = txQ.size() > 0;
        rxAny  = rxQ.size() > 0;
        rxRoom = rxQ.size() < DEPTH;
        @(posedge clk);
        #1;
        if (p && txAny) void'(txQ.pop_front());
        if (p && !txAny) popErrM = 1'b1;
        if (txV && txRoom) txQ.push_back(txD);
        if (rxR && rxAny) void'(rxQ.pop_front());
        if (pu && accepts(puD)) begin
            if (rxRoom) rxQ.push_back(puD);
            else if (dropM < 255) dropM++;
        end
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [7:0] ids [4];
        ids[0] = MY_ID; ids[1] = 8'h05; ids[2] = BCAST; ids[3] = 8'h00;
        reset = 1'b0; pop = 0; push = 0; tx_valid = 0; rx_ready = 0; D_push = '0; tx_data = '0;
        clearModel();
        #12;
        checkOutput();
        #5 reset = 1'b1;
        idle();

        $display("[TB] three device packets through TX");
        applyStimulus(1'b1, mkPkt(8'hA1), 1'b0, 1'b0, '0, 1'b0);
        check1("pndng_after_first_write", PW'(pndng), PW'(1));
        applyStimulus(1'b1, mkPkt(8'hA2), 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, mkPkt(8'hA3), 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check1("pndng_after_drain", PW'(pndng), PW'(0));

        $display("[TB] TX full with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, mkPkt(8'hB0), 1'b0, 1'b0, '0, 1'b0);
        check1("tx_ready_full", PW'(tx_ready), PW'(0));
        applyStimulus(1'b1, mkPkt(8'hBF), 1'b1, 1'b0, '0, 1'b0);
        check1("tx_ready_after_pop", PW'(tx_ready), PW'(1));
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        $display("[TB] RX overflow");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, mkPkt(MY_ID), 1'b0);
        check1("drop_cnt_overflow", PW'(rx_drop_cnt), PW'(2));
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] destination filter");
        applyStimulus(1'b0, '0, 1'b0, 1'b1, mkPkt(8'h03), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, mkPkt(8'h05), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, mkPkt(8'hFF), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] pop on empty TX");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check1("pop_err_set", PW'(pop_err), PW'(1));
        idle();
        idle();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(bit'($urandom_range(0, 1)), mkPkt(8'($urandom)),
                          bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
                          mkPkt(ids[$urandom_range(0, 3)]), bit'($urandom_range(0, 3) == 0));

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 20 && (txQ.size() > 0 || rxQ.size() > 0); i++)
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        check1("drained_before_fill", PW'(pndng | rx_valid), PW'(0));
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mkPkt(8'hC0), 1'b0, 1'b1, mkPkt(MY_ID), 1'b0);
        #2 reset = 1'b0;
        #1;
        clearModel();
        checkOutput();
        @(negedge clk) reset = 1'b1;
        idle();
        applyStimulus(1'b1, mkPkt(8'hD1), 1'b0, 1'b1, mkPkt(BCAST), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
